// File: rtl/pll_reset_seq.sv
// PLL reset and lock sequencer: pulses pll_rst, qualifies lock, then releases sys_rst.
// Optional lock watchdog in WAIT_LOCK is compiled in with `define PLL_WATCHDOG_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_PLL_RST   | pll_rst held high for RST_PULSE cycles
// S_WAIT_LOCK | PLL running, waiting for synchronized lock (optional timeout)
// S_STABLE    | lock seen, counting STABLE_CYCLES consecutive locked cycles
// S_RUN       | core out of reset, watching for lock loss / ext_rst_req
module pll_reset_seq #(
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked_in,
  input  logic       ext_rst_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] relock_cnt
);

  localparam int MAX_A = (RST_PULSE > STABLE_CYCLES) ? RST_PULSE : STABLE_CYCLES;
  localparam int MAX_P = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
  localparam int CW    = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] RST_LOAD = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] STB_LOAD = CW'(STABLE_CYCLES - 1);
`ifdef PLL_WATCHDOG_EN
  localparam logic [CW-1:0] WDT_LOAD = CW'(LOCK_TIMEOUT - 1);
`else
  localparam logic [CW-1:0] WDT_LOAD = '0;
`endif

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync_q;
  logic          locked_s;

  // locked_in is asynchronous to clk; only sync_q[0] ever samples it
  assign locked_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_PLL_RST;
      cnt        <= RST_LOAD;
      sync_q     <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      ready      <= 1'b0;
      relock_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], locked_in};
      case (state)
        S_PLL_RST: begin
          if (cnt == '0) begin
            state   <= S_WAIT_LOCK;
            cnt     <= WDT_LOAD;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state <= S_STABLE;
            cnt   <= STB_LOAD;
          end
`ifdef PLL_WATCHDOG_EN
          else if (cnt == '0) begin
            state   <= S_PLL_RST;
            cnt     <= RST_LOAD;
            pll_rst <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
`endif
        end
        S_STABLE: begin
          // any unlocked cycle restarts qualification without touching the PLL
          if (!locked_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= WDT_LOAD;
          end else if (cnt == '0) begin
            state   <= S_RUN;
            sys_rst <= 1'b0;
            ready   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RUN: begin
          // lock loss outranks a simultaneous ext_rst_req
          if (!locked_s) begin
            state   <= S_PLL_RST;
            cnt     <= RST_LOAD;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
            if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
          end else if (ext_rst_req) begin
            state   <= S_STABLE;
            cnt     <= STB_LOAD;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= S_PLL_RST;
          cnt     <= RST_LOAD;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule
